bitbang_host_if: RTL and testbench

FPGA-side endpoint of the host bit-bang link: RxD/RxC/RxTxR inbound, TxD/TxC outbound.
- Deserialises 64 host bytes into a 256-bit midstate and a 256-bit data word, and hands them to the hashing core.
- Queues golden nonces from the core and serialises them to the host as flag-framed bytes, clocked by the host.
- Sits between fpgaminer_top's pins and the SHA core.

---
 rtl/bitbang_pkg.sv | 39 +++
 rtl/bitbang_nonce_fifo.sv | 66 ++++++
 rtl/bitbang_host_if.sv | 184 ++++++++++++++++++
 tb/tb_bitbang_host_if.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bitbang_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bitbang_pkg
//  Description : Shared constants, tx state encoding and the nonce frame byte
//                selector for the host bit-bang endpoint.
//  Revision    : 1.0  initial release
// ============================================================================
package bitbang_pkg;

    localparam int   WORK_BYTES  = 64;
    localparam int   NONCE_BYTES = 4;
    localparam int   NONCE_W     = 32;
    localparam logic FLAG_BIT    = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BITS = 2'd1,
        NEXT = 2'd2
    } tx_state_t;

    // Byte carried by frame idx of a nonce: bytes 0..3 LSB first, idx 4 is
    // the XOR of all four (only reached when the checksum frame is enabled).
    function automatic logic [7:0] nonce_frame_byte(
        input logic [NONCE_W-1:0] word,
        input logic [2:0]         idx
    );
        logic [7:0] frame_byte;
        case (idx)
            3'd0:    frame_byte = word[7:0];
            3'd1:    frame_byte = word[15:8];
            3'd2:    frame_byte = word[23:16];
            3'd3:    frame_byte = word[31:24];
            default: frame_byte = word[7:0] ^ word[15:8] ^ word[23:16] ^ word[31:24];
        endcase
        return frame_byte;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bitbang_nonce_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : bitbang_nonce_fifo
//  Description : Golden-nonce queue, first-word fall-through. A push while
//                full is dropped (sticky o_dropped) unless a pop happens in
//                the same cycle, in which case the push is accepted.
//  Revision    : 1.0  initial release
// ============================================================================
module bitbang_nonce_fifo
    import bitbang_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_push,
    input  logic [NONCE_W-1:0] i_push_data,
    input  logic               i_pop,
    output logic [NONCE_W-1:0] o_pop_data,
    output logic               o_empty,
    output logic               o_dropped
);

    localparam int c_addr_w = $clog2(FIFO_DEPTH);

    logic [NONCE_W-1:0]  r_mem [FIFO_DEPTH];
    logic [c_addr_w-1:0] r_wr_ptr;
    logic [c_addr_w-1:0] r_rd_ptr;
    logic [c_addr_w:0]   r_count;

    logic w_full;
    logic w_do_pop;
    logic w_do_push;

    assign w_full     = (r_count == (c_addr_w + 1)'(FIFO_DEPTH));
    assign o_empty    = (r_count == '0);
    assign w_do_pop   = i_pop & ~o_empty;
    assign w_do_push  = i_push & (~w_full | w_do_pop);
    assign o_pop_data = r_mem[r_rd_ptr];

    // Pointers and occupancy; pointers wrap naturally as DEPTH is a power of two
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            o_dropped <= 1'b0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (i_push && !w_do_push) o_dropped <= 1'b1;
        end
    end

    // Storage array, no reset needed: occupancy decides what is valid
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_push_data;
    end

endmodule
`default_nettype wire

// File: rtl/bitbang_host_if.sv
`default_nettype none
// ============================================================================
//  Module      : bitbang_host_if
//  Description : FPGA endpoint of the host bit-bang link. Deserialises 64
//                host bytes into midstate/data work and serialises queued
//                golden nonces back as flag-framed bytes clocked by TxC.
//                Define BITBANG_TX_CHECKSUM_EN to append an XOR checksum
//                frame after the four nonce bytes.
//  Revision    : 1.0  initial release
// ============================================================================
module bitbang_host_if
    import bitbang_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         RxD,
    input  logic         RxC,
    input  logic         RxTxR,
    input  logic         TxC,
    output logic         TxD,
    input  logic [31:0]  golden_nonce,
    input  logic         golden_nonce_valid,
    output logic [255:0] midstate,
    output logic [255:0] data,
    output logic         work_valid,
    output logic         rx_overflow,
    output logic         nonce_dropped
);

    localparam logic [6:0] c_work_bytes = 7'(WORK_BYTES);
`ifdef BITBANG_TX_CHECKSUM_EN
    localparam logic [2:0] c_last_byte_idx = 3'(NONCE_BYTES);
`else
    localparam logic [2:0] c_last_byte_idx = 3'(NONCE_BYTES - 1);
`endif

    // ---------------------------------------------------------------- sync
    // Bit order in the synchroniser: 0=RxD 1=RxC 2=RxTxR 3=TxC
    logic [3:0] w_pins;
    logic [3:0] r_sync [SYNC_STAGES];
    logic [3:1] r_sync_dly;
    logic [3:0] w_sync;
    logic       w_rxd;
    logic       w_rxc_rise;
    logic       w_rxtxr_rise;
    logic       w_txc_fall;

    assign w_pins = {TxC, RxTxR, RxC, RxD};
    assign w_sync = r_sync[SYNC_STAGES-1];

    // Synchronise host pins and keep a one-cycle delayed copy for edge detect
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
            r_sync_dly <= '0;
        end else begin
            r_sync[0] <= w_pins;
            for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
            r_sync_dly <= w_sync[3:1];
        end
    end

    assign w_rxd        = w_sync[0];
    assign w_rxc_rise   =  w_sync[1] & ~r_sync_dly[1];
    assign w_rxtxr_rise =  w_sync[2] & ~r_sync_dly[2];
    assign w_txc_fall   = ~w_sync[3] &  r_sync_dly[3];

    // ------------------------------------------------------------------ rx
    logic [7:0]   r_rx_shift;
    logic [2:0]   r_rx_bit_cnt;
    logic [6:0]   r_byte_cnt;
    logic [511:0] r_work;
    logic [7:0]   w_rx_byte;

    assign w_rx_byte = {w_rxd, r_rx_shift[7:1]};

    // Receive path: bit/byte assembly, overflow tracking and work hand-off
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rx_shift   <= '0;
            r_rx_bit_cnt <= '0;
            r_byte_cnt   <= '0;
            r_work       <= '0;
            midstate     <= '0;
            data         <= '0;
            work_valid   <= 1'b0;
            rx_overflow  <= 1'b0;
        end else begin
            work_valid <= 1'b0;
            if (w_rxtxr_rise) begin
                // Only an exact, byte-aligned 64-byte burst counts as work
                if (r_byte_cnt == c_work_bytes && r_rx_bit_cnt == 3'd0) begin
                    midstate   <= r_work[511:256];
                    data       <= r_work[255:0];
                    work_valid <= 1'b1;
                end
                r_byte_cnt   <= '0;
                r_rx_bit_cnt <= '0;
                rx_overflow  <= 1'b0;
            end else if (w_rxc_rise) begin
                r_rx_shift   <= w_rx_byte;
                r_rx_bit_cnt <= r_rx_bit_cnt + 1'b1;
                if (r_rx_bit_cnt == 3'd7) begin
                    if (r_byte_cnt < c_work_bytes)  r_work     <= {r_work[503:0], w_rx_byte};
                    if (r_byte_cnt <= c_work_bytes) r_byte_cnt <= r_byte_cnt + 1'b1;
                    if (r_byte_cnt == c_work_bytes) rx_overflow <= 1'b1;
                end
            end
        end
    end

    // ---------------------------------------------------------------- fifo
    logic [NONCE_W-1:0] w_fifo_data;
    logic               w_fifo_empty;
    logic               w_pop;

    bitbang_nonce_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_nonce_fifo (
        .clk         (clk),
        .rst         (reset),
        .i_push      (golden_nonce_valid),
        .i_push_data (golden_nonce),
        .i_pop       (w_pop),
        .o_pop_data  (w_fifo_data),
        .o_empty     (w_fifo_empty),
        .o_dropped   (nonce_dropped)
    );

    // ------------------------------------------------------------------ tx
    tx_state_t          r_tx_state;
    logic [NONCE_W-1:0] r_tx_word;
    logic [2:0]         r_byte_idx;
    logic [3:0]         r_tx_bit_cnt;
    logic               w_tx_last;
    logic               w_tx_idle_rule;
    logic [2:0]         w_bit_idx;
    logic [7:0]         w_cur_byte;

    assign w_tx_last      = (r_byte_idx == c_last_byte_idx);
    // IDLE, or NEXT after the final frame, both fall through to the IDLE rule
    assign w_tx_idle_rule = (r_tx_state == IDLE) || (r_tx_state == NEXT && w_tx_last);
    assign w_pop          = w_txc_fall & ~w_rxtxr_rise & w_tx_idle_rule & ~w_fifo_empty;
    assign w_bit_idx      = 3'(4'd8 - r_tx_bit_cnt);
    assign w_cur_byte     = nonce_frame_byte(r_tx_word, r_byte_idx);

    // Transmit FSM, stepped only by host TxC falling edges
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tx_state   <= IDLE;
            r_tx_word    <= '0;
            r_byte_idx   <= '0;
            r_tx_bit_cnt <= '0;
            TxD          <= 1'b0;
        end else if (w_rxtxr_rise) begin
            r_tx_state <= IDLE;
        end else if (w_txc_fall) begin
            if (r_tx_state == BITS) begin
                TxD          <= w_cur_byte[w_bit_idx];
                r_tx_bit_cnt <= r_tx_bit_cnt - 1'b1;
                if (r_tx_bit_cnt == 4'd1) r_tx_state <= NEXT;
            end else if (r_tx_state == NEXT && !w_tx_last) begin
                r_byte_idx   <= r_byte_idx + 1'b1;
                r_tx_bit_cnt <= 4'd8;
                TxD          <= FLAG_BIT;
                r_tx_state   <= BITS;
            end else if (!w_fifo_empty) begin
                r_tx_word    <= w_fifo_data;
                r_byte_idx   <= '0;
                r_tx_bit_cnt <= 4'd8;
                TxD          <= FLAG_BIT;
                r_tx_state   <= BITS;
            end else begin
                TxD        <= 1'b0;
                r_tx_state <= IDLE;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bitbang_host_if.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bitbang_host_if
//  Description : Self-checking bench for bitbang_host_if: host-side bit-bang
//                driver plus a byte/nonce-queue reference model.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_bitbang_host_if;

    localparam int FIFO_DEPTH  = 4;
    localparam int SYNC_STAGES = 2;
    localparam int HOLD        = 10;
`ifdef BITBANG_TX_CHECKSUM_EN
    localparam int N_FRAMES = 5;
`else
    localparam int N_FRAMES = 4;
`endif

    localparam logic [255:0] VEC_MID  = 256'h2b3f81261b3cfd001db436cfd4c8f3f9c7450c9a0d049bee71cba0ea2619c0b5;
    localparam logic [255:0] VEC_DATA = 256'h000000000000000000000000_80000000_00000000_39f3001b6b7b8d4dc14bfc31;

    logic         clk = 1'b0;
    logic         reset;
    logic         RxD, RxC, RxTxR, TxC, TxD;
    logic [31:0]  golden_nonce;
    logic         golden_nonce_valid;
    logic [255:0] midstate, data;
    logic         work_valid, rx_overflow, nonce_dropped;

    int n_pass  = 0;
    int n_total = 0;
    int wv_seen = 0;

    // Reference model state
    logic [255:0] exp_mid  = '0;
    logic [255:0] exp_data = '0;
    int           exp_wv   = 0;
    logic [7:0]   rx_bytes[$];
    int           rx_bits  = 0;
    logic [31:0]  nq[$];
    logic         exp_dropped = 1'b0;

    always #5 clk = ~clk;

    bitbang_host_if #(
        .FIFO_DEPTH  (FIFO_DEPTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .RxD                (RxD),
        .RxC                (RxC),
        .RxTxR              (RxTxR),
        .TxC                (TxC),
        .TxD                (TxD),
        .golden_nonce       (golden_nonce),
        .golden_nonce_valid (golden_nonce_valid),
        .midstate           (midstate),
        .data               (data),
        .work_valid         (work_valid),
        .rx_overflow        (rx_overflow),
        .nonce_dropped      (nonce_dropped)
    );

    always @(negedge clk) if (work_valid) wv_seen++;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Advance n rising edges and settle 1 ns past the last one
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] exp_frame(input logic [31:0] n, input int k);
        logic [7:0] b [5];
        b[0] = n[7:0];
        b[1] = n[15:8];
        b[2] = n[23:16];
        b[3] = n[31:24];
        b[4] = b[0] ^ b[1] ^ b[2] ^ b[3];
        return b[k];
    endfunction

    // ---------------------------------------------------------- host rx side
    task automatic send_bit(input logic b);
        RxD = b;
        tick(HOLD);
        RxC = 1'b1;
        tick(HOLD);
        RxC = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 0; i < 8; i++) send_bit(v[i]);
        rx_bytes.push_back(v);
    endtask

    task automatic send_rand_bytes(input int n);
        for (int i = 0; i < n; i++) send_byte(8'($urandom));
    endtask

    task automatic send_rand_bits(input int n);
        for (int i = 0; i < n; i++) send_bit(1'($urandom));
        rx_bits = n;
    endtask

    task automatic rxtxr_pulse();
        bit           load;
        logic [511:0] fr;
        load = (rx_bytes.size() == 64) && (rx_bits == 0);
        RxTxR = 1'b1;
        for (int c = 1; c <= SYNC_STAGES + 2; c++) begin
            @(posedge clk);
            @(negedge clk);
            chk("work_valid_timing", work_valid, (load && c == SYNC_STAGES + 1));
        end
        tick(1);
        tick(HOLD);
        RxTxR = 1'b0;
        tick(HOLD);
        if (load) begin
            for (int i = 0; i < 64; i++) fr[511 - 8*i -: 8] = rx_bytes[i];
            exp_mid  = fr[511:256];
            exp_data = fr[255:0];
            exp_wv++;
        end
        rx_bytes.delete();
        rx_bits = 0;
        chk("work_valid_count", wv_seen, exp_wv);
        chk("midstate", midstate, exp_mid);
        chk("data", data, exp_data);
        chk("rx_overflow_clear", rx_overflow, 1'b0);
    endtask

    // ---------------------------------------------------------- host tx side
    task automatic model_push(input logic [31:0] n);
        if (nq.size() < FIFO_DEPTH) nq.push_back(n);
        else exp_dropped = 1'b1;
    endtask

    task automatic push(input logic [31:0] n);
        golden_nonce       = n;
        golden_nonce_valid = 1'b1;
        tick(1);
        golden_nonce_valid = 1'b0;
        model_push(n);
    endtask

    // One TxC poll; with do_push a nonce is pushed in the pop cycle
    task automatic poll(output logic b, input bit do_push, input logic [31:0] n);
        TxC = 1'b1;
        tick(HOLD);
        TxC = 1'b0;
        if (do_push) begin
            tick(SYNC_STAGES);
            golden_nonce       = n;
            golden_nonce_valid = 1'b1;
            tick(1);
            golden_nonce_valid = 1'b0;
            tick(HOLD - SYNC_STAGES - 1);
        end else begin
            tick(HOLD);
        end
        @(negedge clk);
        b = TxD;
        tick(1);
    endtask

    task automatic read_nonce(input bit push_on_pop, input logic [31:0] n);
        logic [31:0] exp_n;
        logic [7:0]  byt;
        logic        b;
        exp_n = nq.pop_front();
        for (int k = 0; k < N_FRAMES; k++) begin
            poll(b, push_on_pop && k == 0, n);
            if (push_on_pop && k == 0) model_push(n);
            chk("tx_flag", b, 1'b1);
            for (int j = 0; j < 8; j++) begin
                poll(b, 1'b0, '0);
                byt[j] = b;
            end
            chk("tx_byte", byt, exp_frame(exp_n, k));
        end
    endtask

    task automatic expect_idle();
        logic b;
        poll(b, 1'b0, '0);
        chk("tx_idle", b, 1'b0);
    endtask

    // ---------------------------------------------------------------- steps
    initial begin
        logic        b;
        logic [31:0] na, nb;

        reset = 1'b1;
        RxD = 1'b0; RxC = 1'b0; RxTxR = 1'b0; TxC = 1'b0;
        golden_nonce = '0; golden_nonce_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_TxD", TxD, 1'b0);
        chk("rst_midstate", midstate, '0);
        chk("rst_data", data, '0);
        chk("rst_work_valid", work_valid, 1'b0);
        chk("rst_rx_overflow", rx_overflow, 1'b0);
        chk("rst_nonce_dropped", nonce_dropped, 1'b0);
        @(posedge clk);
        #1 reset = 1'b0;
        tick(2);

        // Empty RxTxR, then the reference work vector
        rxtxr_pulse();
        for (int i = 0; i < 32; i++) send_byte(VEC_MID[255 - 8*i -: 8]);
        for (int i = 0; i < 32; i++) send_byte(VEC_DATA[255 - 8*i -: 8]);
        chk("vec_no_overflow", rx_overflow, 1'b0);
        rxtxr_pulse();
        chk("vec_midstate", midstate, VEC_MID);
        chk("vec_data", data, VEC_DATA);

        // Reference nonce
        expect_idle();
        expect_idle();
        push(32'h01D00BDC);
        read_nonce(1'b0, '0);
        expect_idle();
        expect_idle();

        // Short and long bursts never load work
        send_rand_bytes(63);
        rxtxr_pulse();
        send_rand_bytes(65);
        chk("rx_overflow_set", rx_overflow, 1'b1);
        rxtxr_pulse();

        // Partial byte discarded by RxTxR, then random full work
        send_rand_bits(3);
        rxtxr_pulse();
        send_rand_bytes(64);
        rxtxr_pulse();
        send_rand_bytes(64);
        send_rand_bits(3);
        rxtxr_pulse();

        // FIFO overflow, then drain with a push landing on the first pop
        chk("dropped_before", nonce_dropped, exp_dropped);
        for (int i = 0; i <= FIFO_DEPTH; i++) push($urandom);
        chk("dropped_after", nonce_dropped, exp_dropped);
        read_nonce(1'b1, $urandom);
        while (nq.size() > 0) read_nonce(1'b0, '0);
        expect_idle();
        chk("dropped_sticky", nonce_dropped, 1'b1);

        // RxTxR during the second byte of a nonce
        na = $urandom;
        nb = $urandom;
        push(na);
        push(nb);
        void'(nq.pop_front());
        for (int i = 0; i < 12; i++) poll(b, 1'b0, '0);
        rxtxr_pulse();
        read_nonce(1'b0, '0);
        expect_idle();

        // Asynchronous reset mid-frame
        push($urandom);
        poll(b, 1'b0, '0);
        #2 reset = 1'b1;
        #1;
        chk("arst_TxD", TxD, 1'b0);
        chk("arst_midstate", midstate, '0);
        chk("arst_data", data, '0);
        chk("arst_nonce_dropped", nonce_dropped, 1'b0);
        chk("arst_rx_overflow", rx_overflow, 1'b0);
        tick(3);
        reset = 1'b0;
        nq.delete();
        exp_dropped = 1'b0;
        tick(2);
        expect_idle();
        chk("arst_dropped_after", nonce_dropped, exp_dropped);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
